// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin port-A controller with power-up RAM zeroing sweep
// Optional build macro: RAM_ARB_RDATA_REG_EN (adds an output register stage, read latency T+2)
module ram_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Req0Valid,
    input  logic                 Req0Write,
    input  logic [ADDRWIDTH-1:0] Req0Addr,
    input  logic [DATAWIDTH-1:0] Req0WData,
    output logic                 Req0Ready,
    output logic                 Rsp0Valid,
    output logic [DATAWIDTH-1:0] Rsp0RData,
    input  logic                 Req1Valid,
    input  logic                 Req1Write,
    input  logic [ADDRWIDTH-1:0] Req1Addr,
    input  logic [DATAWIDTH-1:0] Req1WData,
    output logic                 Req1Ready,
    output logic                 Rsp1Valid,
    output logic [DATAWIDTH-1:0] Rsp1RData,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut,
    output logic                 InitDone
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDRWIDTH-1:0] LastInitAddr = '1;

    state_t               State;
    logic [ADDRWIDTH-1:0] InitCnt;
    logic [ADDRWIDTH-1:0] LastAddr;
    logic                 Ptr;
    logic                 Grant0;
    logic                 Grant1;
    logic                 ReadAcc;
    logic                 RdPend;
    logic                 RdId;

    // Round-robin grant: a lone requester always wins, contention goes to the pointer's choice
    always_comb begin
        Grant0 = 1'b0;
        Grant1 = 1'b0;
        if (State == RUN) begin
            Grant0 = Req0Valid && (!Req1Valid || !Ptr);
            Grant1 = Req1Valid && (!Req0Valid || Ptr);
        end
    end

    assign Req0Ready = Grant0;
    assign Req1Ready = Grant1;
    assign ReadAcc   = (Grant0 && !Req0Write) || (Grant1 && !Req1Write);

    // Port A mux: init sweep, granted request, or an idle read of the last address
    always_comb begin
        RamAddr        = LastAddr;
        RamDataIn      = '0;
        RamWriteEnable = 1'b0;
        if (State == INIT) begin
            RamAddr        = InitCnt;
            RamWriteEnable = 1'b1;
        end else if (Grant0) begin
            RamAddr        = Req0Addr;
            RamDataIn      = Req0WData;
            RamWriteEnable = Req0Write;
        end else if (Grant1) begin
            RamAddr        = Req1Addr;
            RamDataIn      = Req1WData;
            RamWriteEnable = Req1Write;
        end
    end

    // Control FSM: zeroing sweep, then arbitration with priority-pointer update
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            State    <= INIT;
            InitCnt  <= '0;
            Ptr      <= 1'b0;
            InitDone <= 1'b0;
            LastAddr <= '0;
        end else begin
            LastAddr <= RamAddr;
            if (State == INIT) begin
                if (InitCnt == LastInitAddr) begin
                    State    <= RUN;
                    InitDone <= 1'b1;
                end else begin
                    InitCnt <= InitCnt + 1'b1;
                end
            end else begin
                if (Grant0) begin
                    Ptr <= 1'b1;
                end else if (Grant1) begin
                    Ptr <= 1'b0;
                end
            end
        end
    end

    // Remember that a read was issued and by whom, so the RAM output can be routed next cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            RdPend <= 1'b0;
            RdId   <= 1'b0;
        end else begin
            RdPend <= ReadAcc;
            RdId   <= Grant1;
        end
    end

`ifdef RAM_ARB_RDATA_REG_EN
    logic                 Valid0Q;
    logic                 Valid1Q;
    logic [DATAWIDTH-1:0] RData0Q;
    logic [DATAWIDTH-1:0] RData1Q;

    // Second response stage: capture RAM data into the owning port's register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Valid0Q <= 1'b0;
            Valid1Q <= 1'b0;
            RData0Q <= '0;
            RData1Q <= '0;
        end else begin
            Valid0Q <= RdPend && !RdId;
            Valid1Q <= RdPend && RdId;
            if (RdPend && !RdId) begin
                RData0Q <= RamDataOut;
            end
            if (RdPend && RdId) begin
                RData1Q <= RamDataOut;
            end
        end
    end

    assign Rsp0Valid = Valid0Q;
    assign Rsp1Valid = Valid1Q;
    assign Rsp0RData = RData0Q;
    assign Rsp1RData = RData1Q;
`else
    logic [DATAWIDTH-1:0] Hold0;
    logic [DATAWIDTH-1:0] Hold1;

    // Keep each port's last delivered word so the idle port's data does not follow the RAM
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Hold0 <= '0;
            Hold1 <= '0;
        end else begin
            if (RdPend && !RdId) begin
                Hold0 <= RamDataOut;
            end
            if (RdPend && RdId) begin
                Hold1 <= RamDataOut;
            end
        end
    end

    assign Rsp0Valid = RdPend && !RdId;
    assign Rsp1Valid = RdPend && RdId;
    assign Rsp0RData = Rsp0Valid ? RamDataOut : Hold0;
    assign Rsp1RData = Rsp1Valid ? RamDataOut : Hold1;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

    localparam int DEPTH = 16;
`ifdef RAM_ARB_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req0Valid = 1'b0, Req0Write = 1'b0, Req0Ready, Rsp0Valid;
    logic [3:0]  Req0Addr = '0;
    logic [31:0] Req0WData = '0, Rsp0RData;
    logic        Req1Valid = 1'b0, Req1Write = 1'b0, Req1Ready, Rsp1Valid;
    logic [3:0]  Req1Addr = '0;
    logic [31:0] Req1WData = '0, Rsp1RData;
    logic [3:0]  RamAddr;
    logic [31:0] RamDataIn, RamDataOut;
    logic        RamWriteEnable, InitDone;

    ram_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0Valid(Req0Valid), .Req0Write(Req0Write), .Req0Addr(Req0Addr),
        .Req0WData(Req0WData), .Req0Ready(Req0Ready),
        .Rsp0Valid(Rsp0Valid), .Rsp0RData(Rsp0RData),
        .Req1Valid(Req1Valid), .Req1Write(Req1Write), .Req1Addr(Req1Addr),
        .Req1WData(Req1WData), .Req1Ready(Req1Ready),
        .Rsp1Valid(Rsp1Valid), .Rsp1RData(Rsp1RData),
        .RamAddr(RamAddr), .RamDataIn(RamDataIn), .RamWriteEnable(RamWriteEnable),
        .RamDataOut(RamDataOut), .InitDone(InitDone)
    );

    always #5 Clk = ~Clk;

    // Single-port RAM: registered read, write cycles leave the read data untouched
    logic [31:0] ram_mem [DEPTH];
    always @(posedge Clk) begin
        if (RamWriteEnable) ram_mem[RamAddr] <= RamDataIn;
        else                RamDataOut <= ram_mem[RamAddr];
    end

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: shadow memory, turn variable, queue of expected responses
    typedef struct { int id; logic [31:0] data; int due; } rsp_t;
    rsp_t        q[$];
    logic [31:0] smem [DEPTH];
    logic [31:0] hold0, hold1, last_rsp0, last_rsp1;
    int          k, icnt, turn, last_addr, init_we, done_cyc, n_rsp1;
    bit          acc0, acc1, rec_on;
    int          gseq[$];

    always @(negedge Clk) begin
        int g;
        bit e0, e1;
        if (Rst) begin
            chk("rst_rsp0v", 32'(Rsp0Valid), 0);
            chk("rst_rsp1v", 32'(Rsp1Valid), 0);
            chk("rst_initdone", 32'(InitDone), 0);
            q.delete();
            k = 0; icnt = 0; turn = 0; last_addr = 0;
            hold0 = 0; hold1 = 0; init_we = 0; done_cyc = 0;
            acc0 = 0; acc1 = 0;
        end else begin
            if (!InitDone && RamWriteEnable) init_we++;
            if (InitDone && done_cyc == 0) done_cyc = k + 1;
            acc0 = Req0Ready;
            acc1 = Req1Ready;
            if (icnt < DEPTH) begin
                chk("init_we", 32'(RamWriteEnable), 1);
                chk("init_addr", 32'(RamAddr), 32'(icnt));
                chk("init_din", RamDataIn, 0);
                chk("init_rdy", {30'd0, Req1Ready, Req0Ready}, 0);
                chk("init_done_low", 32'(InitDone), 0);
                smem[icnt] = 0;
                last_addr = icnt;
                icnt++;
            end else begin
                chk("run_initdone", 32'(InitDone), 1);
                g = -1;
                if (Req0Valid && Req1Valid) g = turn;
                else if (Req0Valid)         g = 0;
                else if (Req1Valid)         g = 1;
                chk("rdy0", 32'(Req0Ready), 32'(g == 0));
                chk("rdy1", 32'(Req1Ready), 32'(g == 1));
                if (g >= 0) begin
                    logic        wr;
                    logic [3:0]  a;
                    logic [31:0] d;
                    wr = (g == 0) ? Req0Write : Req1Write;
                    a  = (g == 0) ? Req0Addr  : Req1Addr;
                    d  = (g == 0) ? Req0WData : Req1WData;
                    chk("ram_we", 32'(RamWriteEnable), 32'(wr));
                    chk("ram_addr", 32'(RamAddr), 32'(a));
                    if (wr) begin
                        chk("ram_din", RamDataIn, d);
                        smem[a] = d;
                    end else begin
                        q.push_back('{id: g, data: smem[a], due: k + LAT});
                    end
                    last_addr = int'(a);
                    turn = 1 - g;
                    if (rec_on) gseq.push_back(g);
                end else begin
                    chk("idle_we", 32'(RamWriteEnable), 0);
                    chk("idle_addr", 32'(RamAddr), 32'(last_addr));
                end
            end
            e0 = 0; e1 = 0;
            if (q.size() > 0 && q[0].due <= k) begin
                if (q[0].id == 0) begin e0 = 1; hold0 = q[0].data; end
                else              begin e1 = 1; hold1 = q[0].data; end
                void'(q.pop_front());
            end
            chk("rsp0v", 32'(Rsp0Valid), 32'(e0));
            chk("rsp1v", 32'(Rsp1Valid), 32'(e1));
            chk("rsp0data", Rsp0RData, hold0);
            chk("rsp1data", Rsp1RData, hold1);
            if (Rsp0Valid) last_rsp0 = Rsp0RData;
            if (Rsp1Valid) begin last_rsp1 = Rsp1RData; n_rsp1++; end
            k++;
        end
    end

    task automatic issue(input int n, input logic wr, input logic [3:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        if (n == 0) begin Req0Valid = 1; Req0Write = wr; Req0Addr = a; Req0WData = d; end
        else        begin Req1Valid = 1; Req1Write = wr; Req1Addr = a; Req1WData = d; end
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge Clk);
            got = (n == 0) ? Req0Ready : Req1Ready;
        end
        chk("issue_accept", 32'(got), 1);
        @(posedge Clk); #1;
        if (n == 0) Req0Valid = 0; else Req1Valid = 0;
    endtask

    task automatic idle(input int nc);
        repeat (nc) @(posedge Clk);
        #1;
    endtask

    task automatic wait_init;
        bit ok;
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge Clk);
            ok = InitDone;
        end
        chk("init_timeout", 32'(ok), 1);
        @(posedge Clk); #1;
        chk("init_we_cycles", 32'(init_we), 16);
        chk("initdone_cycle", 32'(done_cyc), 17);
    endtask

    initial begin
        int exp_g [6];
        bit got;
        exp_g = '{0, 1, 0, 1, 0, 1};
        rec_on = 0; n_rsp1 = 0;
        last_rsp0 = 32'hFFFF_FFFF; last_rsp1 = 32'hFFFF_FFFF;
        repeat (3) @(posedge Clk);
        #1 Rst = 0;
        wait_init();

        // write then read back on requester 0
        issue(0, 1'b1, 4'd3, 32'hA5A5_0001);
        issue(0, 1'b0, 4'd3, 32'h0);
        idle(3);
        chk("s2_rdata", last_rsp0, 32'hA5A5_0001);
        chk("s2_no_rsp1", 32'(n_rsp1), 0);

        // unwritten address, then a write to it during the response cycle
        issue(1, 1'b0, 4'd7, 32'h0);
        issue(0, 1'b1, 4'd7, 32'h1234_5678);
        idle(3);
        chk("s4_rdata", last_rsp1, 32'h0);
        chk("s4_hold", Rsp1RData, 32'h0);

        // contention: leave the pointer favouring requester 0 first
        issue(0, 1'b1, 4'd1, 32'h1111_0001);
        issue(1, 1'b1, 4'd2, 32'h2222_0002);
        gseq.delete();
        rec_on = 1;
        Req0Valid = 1; Req0Write = 0; Req0Addr = 4'd1;
        Req1Valid = 1; Req1Write = 0; Req1Addr = 4'd2;
        idle(6);
        Req0Valid = 0; Req1Valid = 0; rec_on = 0;
        idle(3);
        chk("s3_ngrants", 32'(gseq.size()), 6);
        for (int i = 0; i < 6 && i < gseq.size(); i++) chk("s3_grant", 32'(gseq[i]), 32'(exp_g[i]));
        chk("s3_rdata0", last_rsp0, 32'h1111_0001);
        chk("s3_rdata1", last_rsp1, 32'h2222_0002);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (!Req0Valid || acc0) begin
                Req0Valid = ($urandom_range(0, 3) != 0);
                Req0Write = 1'($urandom_range(0, 1));
                Req0Addr  = 4'($urandom_range(0, 15));
                Req0WData = $urandom;
            end
            if (!Req1Valid || acc1) begin
                Req1Valid = ($urandom_range(0, 3) != 0);
                Req1Write = 1'($urandom_range(0, 1));
                Req1Addr  = 4'($urandom_range(0, 15));
                Req1WData = $urandom;
            end
            idle(1);
        end
        Req0Valid = 0; Req1Valid = 0;
        idle(3);

        // reset while a read is in flight
        issue(0, 1'b1, 4'd3, 32'hDEAD_BEEF);
        Req0Valid = 1; Req0Write = 0; Req0Addr = 4'd3;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge Clk);
            got = Req0Ready;
        end
        chk("s5_accept", 32'(got), 1);
        @(posedge Clk); #1;
        Req0Valid = 0;
        Rst = 1;
        #1;
        chk("s5_drop0", 32'(Rsp0Valid), 0);
        chk("s5_drop1", 32'(Rsp1Valid), 0);
        idle(2);
        Rst = 0;
        wait_init();
        last_rsp0 = 32'hFFFF_FFFF;
        issue(0, 1'b0, 4'd3, 32'h0);
        idle(3);
        chk("s5_rdata", last_rsp0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
